// File: rtl/riscv_ifu_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
package riscv_ifu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } ifu_state_t;

  localparam int unsigned PC_INC     = 4;
  localparam int unsigned ENTRY_XLEN = 32;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [ENTRY_XLEN-1:0] inst;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Power-of-two circular queue with synchronous flush; the caller guarantees
// that push is never asserted while full.
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign do_pop = pop && !empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/riscv_ifu_prefetch.sv
// Single-outstanding instruction prefetcher feeding a small queue.
// Define IFU_PERF_EN to build the fetch/stall performance counters.
module riscv_ifu_prefetch
  import riscv_ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [1:0]      state,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_t      state_q, state_d;
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic            req_hs, push, pop;
  ifu_entry_t      push_entry, head_entry;

  assign mem_req_valid = (state_q == S_FETCH) && fetch_en && !redirect_valid &&
                         (fifo_count < CW'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign req_hs        = mem_req_valid && mem_req_ready;
  assign push          = (state_q == S_WAIT) && mem_resp_valid && !fifo_full;
  assign pop           = out_valid && out_ready;
  assign state         = state_q;

  assign push_entry.pc   = req_pc;
  assign push_entry.inst = mem_resp_data;

  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_empty ? '0 : head_entry.pc;
  assign out_inst  = fifo_empty ? '0 : head_entry.inst;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (redirect_valid)  fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (req_hs)     fetch_pc <= fetch_pc + XLEN'(PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs) req_pc <= fetch_pc;
  end

  // A response arriving alongside a redirect still retires the outstanding
  // request, so the FSM never waits in DRAIN for a reply that already came.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fetch_en) state_d = S_FETCH;
      S_FETCH: begin
        if (req_hs)         state_d = S_WAIT;
        else if (!fetch_en) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (mem_resp_valid)      state_d = fetch_en ? S_FETCH : S_IDLE;
        else if (redirect_valid) state_d = S_DRAIN;
      end
      S_DRAIN: if (mem_resp_valid) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  ifu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ifu_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (redirect_valid),
    .push    (push),
    .pop     (pop),
    .din     (push_entry),
    .dout    (head_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push && !redirect_valid)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (fetch_en && !out_valid)   stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_ifu_prefetch.sv
// Directed bench for riscv_ifu_prefetch: per-cycle vector table plus
// hand-written sequences for queue-full, redirect-flush and async reset.
module tb_riscv_ifu_prefetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en, redirect_valid, mem_req_ready, mem_resp_valid, out_ready;
  logic [31:0] redirect_pc, mem_resp_data;
  logic        mem_req_valid, out_valid;
  logic [31:0] mem_req_addr, out_pc, out_inst, perf_fetch_cnt, perf_stall_cnt;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_ifu_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .state          (state),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fe, rv, rpc, rdy, rsv, rdata, ordy;
    logic [31:0] st, rqv, addr, ov, opc, oinst;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [31:0] fe, rv, rpc, rdy, rsv, rdata, ordy,
                              input logic [31:0] st, rqv, addr, ov, opc, oinst);
    vec_t v;
    v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rsv = rsv; v.rdata = rdata;
    v.ordy = ordy; v.st = st; v.rqv = rqv; v.addr = addr; v.ov = ov; v.opc = opc;
    v.oinst = oinst;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic drv(input logic fe, rv, input logic [31:0] rpc, input logic rdy, rsv,
                     input logic [31:0] rd, input logic ordy);
    @(negedge clk);
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    mem_req_ready  = rdy;
    mem_resp_valid = rsv;
    mem_resp_data  = rd;
    out_ready      = ordy;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int          hs_cnt;
  logic        pending;
  logic [31:0] pend_data;
  logic [31:0] exp_fetch, exp_stall;

  initial begin
    reset_n = 1'b0;
    fetch_en = 0; redirect_valid = 0; redirect_pc = 0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_data = 0; out_ready = 0;

    //          fe rv rpc           rdy rsv rdata         ordy  st rqv addr          ov opc           oinst
    tv.push_back(mk(1, 0, 0,            1, 0, 0,            1,   0, 0, 32'h0,        0, 0,            0));
    tv.push_back(mk(1, 0, 0,            1, 0, 0,            1,   1, 1, 32'h0,        0, 0,            0));
    tv.push_back(mk(1, 0, 0,            1, 1, 32'hA0,       1,   2, 0, 32'h4,        0, 0,            0));
    tv.push_back(mk(1, 0, 0,            1, 0, 0,            1,   1, 1, 32'h4,        1, 32'h0,        32'hA0));
    tv.push_back(mk(1, 0, 0,            1, 1, 32'hA4,       1,   2, 0, 32'h8,        0, 0,            0));
    tv.push_back(mk(1, 0, 0,            1, 0, 0,            1,   1, 1, 32'h8,        1, 32'h4,        32'hA4));
    tv.push_back(mk(1, 0, 0,            1, 1, 32'hA8,       1,   2, 0, 32'hC,        0, 0,            0));
    tv.push_back(mk(1, 0, 0,            1, 0, 0,            1,   1, 1, 32'hC,        1, 32'h8,        32'hA8));
    tv.push_back(mk(1, 1, 32'h103,      1, 0, 0,            1,   2, 0, 32'h10,       0, 0,            0));
    tv.push_back(mk(1, 0, 0,            1, 1, 32'hDEAD,     1,   3, 0, 32'h100,      0, 0,            0));
    tv.push_back(mk(1, 0, 0,            1, 0, 0,            1,   1, 1, 32'h100,      0, 0,            0));
    tv.push_back(mk(1, 0, 0,            1, 0, 0,            1,   2, 0, 32'h104,      0, 0,            0));
    tv.push_back(mk(1, 0, 0,            1, 1, 32'h1234,     1,   2, 0, 32'h104,      0, 0,            0));
    tv.push_back(mk(0, 0, 0,            1, 0, 0,            0,   1, 0, 32'h104,      1, 32'h100,      32'h1234));
    tv.push_back(mk(0, 0, 0,            1, 0, 0,            1,   0, 0, 32'h104,      1, 32'h100,      32'h1234));
    tv.push_back(mk(0, 1, 32'hFFFFFFFE, 1, 0, 0,            1,   0, 0, 32'h104,      0, 0,            0));
    tv.push_back(mk(1, 0, 0,            1, 0, 0,            1,   0, 0, 32'hFFFFFFFC, 0, 0,            0));
    tv.push_back(mk(1, 0, 0,            0, 0, 0,            1,   1, 1, 32'hFFFFFFFC, 0, 0,            0));
    tv.push_back(mk(1, 0, 0,            1, 0, 0,            1,   1, 1, 32'hFFFFFFFC, 0, 0,            0));
    tv.push_back(mk(0, 0, 0,            1, 1, 32'h55,       1,   2, 0, 32'h0,        0, 0,            0));
    tv.push_back(mk(0, 0, 0,            1, 0, 0,            0,   0, 0, 32'h0,        1, 32'hFFFFFFFC, 32'h55));
    tv.push_back(mk(1, 0, 0,            1, 0, 0,            1,   0, 0, 32'h0,        1, 32'hFFFFFFFC, 32'h55));
    tv.push_back(mk(1, 1, 32'h200,      0, 0, 0,            1,   1, 0, 32'h0,        0, 0,            0));
    tv.push_back(mk(1, 0, 0,            0, 0, 0,            1,   1, 1, 32'h200,      0, 0,            0));
    tv.push_back(mk(0, 0, 0,            0, 0, 0,            1,   1, 0, 32'h200,      0, 0,            0));
    tv.push_back(mk(0, 0, 0,            0, 0, 0,            1,   0, 0, 32'h200,      0, 0,            0));

`ifdef IFU_PERF_EN
    exp_fetch = 32'd4;
    exp_stall = 32'd3;
`else
    exp_fetch = 32'd0;
    exp_stall = 32'd0;
`endif

    // Reset state
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("rst state", 32'(state), 32'd0);
    chk("rst req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst req_addr", mem_req_addr, 32'h0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_pc", out_pc, 32'h0);
    chk("rst out_inst", out_inst, 32'h0);
    chk("rst perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst perf_stall", perf_stall_cnt, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table: streaming fetch, redirect in WAIT/IDLE/FETCH, wrap, fetch_en drop
    foreach (tv[i]) begin
      drv(tv[i].fe[0], tv[i].rv[0], tv[i].rpc, tv[i].rdy[0], tv[i].rsv[0], tv[i].rdata,
          tv[i].ordy[0]);
      chk($sformatf("v%0d state", i), 32'(state), tv[i].st);
      chk($sformatf("v%0d req_valid", i), 32'(mem_req_valid), tv[i].rqv);
      chk($sformatf("v%0d req_addr", i), mem_req_addr, tv[i].addr);
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), tv[i].ov);
      if (tv[i].ov[0]) begin
        chk($sformatf("v%0d out_pc", i), out_pc, tv[i].opc);
        chk($sformatf("v%0d out_inst", i), out_inst, tv[i].oinst);
      end
    end

    // Fill with out_ready=0: exactly DEPTH requests, then fetching stops
    do_reset();
    pending = 1'b0;
    pend_data = '0;
    hs_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      drv(1, 0, 0, 1, pending, pend_data, 0);
      if (mem_req_valid) begin
        hs_cnt++;
        pending = 1'b1;
        pend_data = mem_req_addr + 32'h1000;
      end else begin
        pending = 1'b0;
      end
    end
    chk("full handshakes", 32'(hs_cnt), 32'd4);
    chk("full req_valid", 32'(mem_req_valid), 32'd0);
    chk("full state", 32'(state), 32'd1);
    chk("full out_valid", 32'(out_valid), 32'd1);
    chk("full out_pc", out_pc, 32'h0);
    chk("full out_inst", out_inst, 32'h1000);
    chk("full perf_fetch", perf_fetch_cnt, exp_fetch);
    chk("full perf_stall", perf_stall_cnt, exp_stall);

    // Redirect coinciding with push and pop empties the queue
    drv(1, 0, 0, 1, 0, 0, 1);
    chk("flush pre out_valid", 32'(out_valid), 32'd1);
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("flush req_valid", 32'(mem_req_valid), 32'd1);
    chk("flush req_addr", mem_req_addr, 32'h10);
    drv(1, 1, 32'h203, 1, 1, 32'h99, 1);
    chk("flush wait state", 32'(state), 32'd2);
    chk("flush wait out_valid", 32'(out_valid), 32'd1);
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("flush post out_valid", 32'(out_valid), 32'd0);
    chk("flush post req_valid", 32'(mem_req_valid), 32'd1);
    chk("flush post req_addr", mem_req_addr, 32'h200);
    drv(1, 0, 0, 1, 1, 32'h77, 0);
    chk("refill wait state", 32'(state), 32'd2);
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("refill out_pc", out_pc, 32'h200);
    chk("refill out_inst", out_inst, 32'h77);
    chk("refill req_addr", mem_req_addr, 32'h204);

    // Asynchronous reset while a request is outstanding
    drv(1, 0, 0, 1, 0, 0, 0);
    chk("pre-rst state", 32'(state), 32'd2);
    chk("pre-rst out_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst state", 32'(state), 32'd0);
    chk("arst req_valid", 32'(mem_req_valid), 32'd0);
    chk("arst req_addr", mem_req_addr, 32'h0);
    chk("arst out_valid", 32'(out_valid), 32'd0);
    chk("arst out_pc", out_pc, 32'h0);
    chk("arst out_inst", out_inst, 32'h0);
    chk("arst perf_fetch", perf_fetch_cnt, 32'd0);
    chk("arst perf_stall", perf_stall_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
